// File: rtl/comp_pkg.sv
// Shared definitions for the 7:3 counter compressor family and its
// thermometer-frame serializer companion.
package comp_pkg;

  localparam int COMP73_N  = 7;
  localparam int COMP73_CW = 3;

  typedef logic [COMP73_CW-1:0] count_t;

  typedef enum logic {IDLE, SEND} therm_state_e;

endpackage

// File: rtl/therm_serializer.sv
// Regenerates a unary (thermometer) frame of N bits from a population count,
// one bit per cycle, with valid/ready handshakes on both sides.
module therm_serializer
  import comp_pkg::*;
#(
  parameter int N  = COMP73_N,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_last,
  output logic          sat_err
);

  localparam logic [CW-1:0] N_MAX    = CW'(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam bit            ONE_BIT  = (N == 1);

  therm_state_e  state, state_n;
  logic [CW-1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          bit_n, last_n, sat_n;
  logic          accept, xfer, over;
  logic [CW-1:0] sat_count;

  // Saturation only exists when N is not the largest value CW bits can hold.
  if (N < (1 << CW) - 1) begin : g_sat
    assign over = (in_count > N_MAX);
  end else begin : g_nosat
    assign over = 1'b0;
  end

  assign sat_count = over ? N_MAX : in_count;
  assign out_valid = (state == SEND);
  assign xfer      = out_valid & out_ready;
  assign in_ready  = (state == IDLE) | (xfer & out_last);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      out_bit  <= 1'b0;
      out_last <= 1'b0;
      sat_err  <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      out_bit  <= bit_n;
      out_last <= last_n;
      sat_err  <= sat_n;
    end
  end

  // An accept takes priority so a new frame can start on the last-bit transfer.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    bit_n   = out_bit;
    last_n  = out_last;
    sat_n   = 1'b0;
    if (accept) begin
      state_n = SEND;
      idx_n   = '0;
      cnt_n   = sat_count;
      bit_n   = (sat_count != '0);
      last_n  = ONE_BIT;
      sat_n   = over;
    end else if (xfer) begin
      if (out_last) begin
        state_n = IDLE;
        bit_n   = 1'b0;
        last_n  = 1'b0;
      end else begin
        idx_n  = idx + CW'(1);
        bit_n  = (idx_n < cnt);
        last_n = (idx_n == LAST_IDX);
      end
    end
  end

endmodule

// File: doc/therm_serializer.md
Name: therm_serializer

Overview:
- Inverse-direction companion to the 7:3 counter compressor: takes a population count and regenerates a canonical unary (thermometer) frame of N bits, one bit per cycle.
- Each frame starts at bit index 0. The first `count` bits are 1 and the remaining bits are 0.
- Used to replay compressor results into bit-serial datapaths and as a golden stimulus source for compressor verification.
- Count input and bit output both use valid/ready handshakes.

Parameters:
- N, 7: bits per frame (compressor input width).
- CW, $clog2(N+1) (3 at default): count width.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  count word valid.
- in_ready  output  1  serializer can accept a count this cycle.
- in_count  input  CW  number of ones in the frame.
- out_valid  output  1  out_bit/out_last are valid.
- out_ready  input  1  downstream accepts the current bit.
- out_bit  output  1  current thermometer bit.
- out_last  output  1  current bit is frame bit N-1.
- sat_err  output  1  one-cycle pulse: the accepted count exceeded N and was saturated.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=IDLE; idx=0; cnt=0.
  - out_valid=0, out_bit=0, out_last=0, sat_err=0.
  - in_ready=1.
- Reset asserted mid-frame aborts the frame immediately. No partial frame is resumed after reset.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_valid, out_bit and out_last are registered and hold stable while out_valid=1 & out_ready=0.
  - out_valid never deasserts without a transfer.
- Saturation:
  - On accept, cnt <= min(in_count, N).
  - sat_err pulses the cycle after accept iff in_count > N.
  - At N=7, CW=3, saturation is unreachable, so sat_err stays 0. It is live for N values that are not of the form 2^k-1, e.g. N=6.
- State machine:
  - IDLE: in_ready=1, out_valid=0. On accept go to SEND next cycle with idx=0, out_valid=1, out_bit=(0<cnt'), out_last=(N==1).
  - SEND, no output transfer: hold all state.
  - SEND, transfer with out_last=0: idx<=idx+1, out_bit<=(idx+1<cnt), out_last<=(idx+1==N-1).
  - SEND, transfer with out_last=1: the frame ends.
    - If an input accept occurs in the same cycle, load the new count and start its bit 0 next cycle. Back-to-back frames have no bubble.
    - Otherwise go to IDLE with out_valid<=0.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This is combinational from out_ready. It is the only combinational path.
- Latency:
  - Count accepted at cycle t produces bit 0 valid at t+1.
  - With out_ready held at 1, a frame occupies exactly N cycles.
  - Sustained throughput is one frame per N cycles.
- Width rules:
  - idx is CW bits and never exceeds N-1.
  - Comparisons are unsigned at CW bits.
  - A count of 0 gives an all-zero frame; a count of N gives an all-one frame.
- Simultaneous events: in_valid while SEND and not on the last-bit transfer is not accepted (in_ready=0). Upstream holds the count.
- No X on outputs after reset regardless of input X when in_valid=0.

Decomposition:
- Shared package comp_pkg holds:
  - localparam COMP73_N=7 and COMP73_CW=3;
  - typedef logic [COMP73_CW-1:0] count_t;
  - typedef enum logic {IDLE, SEND} therm_state_e.
- Single module. No sub-module: the per-bit compare is a one-line expression.
- The bench reuses the existing 7:3 compressor as a checker. It packs the 7 serial bits into a word, feeds the compressor and compares the result with the sent count.

Test Plan:
- Reset then in_count=3 with out_ready=1:
  - stream 1,1,1,0,0,0,0;
  - out_last only on the 7th bit;
  - in_ready=0 during bits 0-5.
- Counts 0 and 7: all-zero frame and all-one frame; the compressor checker returns 0 and 7.
- Back-to-back counts 5 then 2 with in_valid held: 1,1,1,1,1,0,0,1,1,0,0,0,0,0 with no idle cycle; second accept coincides with the first frame's out_last transfer.
- Count 4 with out_ready toggling 1,0,0,1,…: bits stable during stalls; sequence still 1,1,1,1,0,0,0; frame length = N transfers.
- N=6 build, in_count=7: frame all ones (6 bits); sat_err=1 for exactly one cycle after accept.
- rst_n asserted mid-frame at bit 3 of count 6: out_valid=0 immediately; after release, in_ready=1; a new count 1 produces 1,0,0,0,0,0,0 cleanly.
